// File: rtl/read_addr_sequencer.sv
// Read-address sequencer for an (N+1)x(N+1) row-major score matrix: three neighbour reads per cell, then publish.
// Optional feature: define RD_SEQ_WAIT_ACK_EN to make WAIT hold until cell_done; otherwise WAIT lasts one cycle.
module read_addr_sequencer #(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cell_done,
    output logic [ADDR_W-1:0] addr,
    output logic              en_read,
    output logic [1:0]        count,
    output logic              signal,
    output logic [IDX_W-1:0]  i,
    output logic [IDX_W-1:0]  j,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(N + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_DIAG,
        S_RD_LEFT,
        S_RD_UP,
        S_EMIT,
        S_WAIT,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] prev_base_q, prev_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        count_q, count_d;
    logic              en_read_q, en_read_d;
    logic              signal_q, signal_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] col_a;
    logic              advance;

`ifdef RD_SEQ_WAIT_ACK_EN
    assign advance = cell_done;
`else
    logic unused_cell_done;
    assign unused_cell_done = cell_done;
    assign advance          = 1'b1;
`endif

    // Next-state, index and row-base update; outputs derive from the next state
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        i_d         = i_q;
        j_d         = j_q;
        row_base_d  = row_base_q;
        prev_base_d = prev_base_q;
        addr_d      = addr_q;
        count_d     = count_q;
        col_a       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RD_DIAG;
                    phase_d     = 1'b0;
                    i_d         = IDX_ONE;
                    j_d         = IDX_ONE;
                    row_base_d  = STRIDE;
                    prev_base_d = '0;
                end
            end
            S_RD_DIAG: begin
                phase_d = ~phase_q;
                if (phase_q) state_d = S_RD_LEFT;
            end
            S_RD_LEFT: begin
                phase_d = ~phase_q;
                if (phase_q) state_d = S_RD_UP;
            end
            S_RD_UP: begin
                phase_d = ~phase_q;
                if (phase_q) state_d = S_EMIT;
            end
            S_EMIT: state_d = S_WAIT;
            S_WAIT: begin
                if (advance) begin
                    if (j_q != IDX_LAST) begin
                        j_d     = j_q + IDX_ONE;
                        state_d = S_RD_DIAG;
                    end else if (i_q != IDX_LAST) begin
                        i_d         = i_q + IDX_ONE;
                        j_d         = IDX_ONE;
                        prev_base_d = row_base_q;
                        row_base_d  = row_base_q + STRIDE;
                        state_d     = S_RD_DIAG;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Neighbour addresses from the row bases: diag/up use the previous row, left the current one
        col_a = ADDR_W'(j_d);
        unique case (state_d)
            S_RD_DIAG: begin
                addr_d  = prev_base_d + col_a - ADDR_ONE;
                count_d = 2'd0;
            end
            S_RD_LEFT: begin
                addr_d  = row_base_d + col_a - ADDR_ONE;
                count_d = 2'd1;
            end
            S_RD_UP: begin
                addr_d  = prev_base_d + col_a;
                count_d = 2'd2;
            end
            default: ;
        endcase

        en_read_d = (state_d == S_RD_DIAG) || (state_d == S_RD_LEFT) || (state_d == S_RD_UP);
        signal_d  = (state_d == S_EMIT);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            row_base_q  <= '0;
            prev_base_q <= '0;
            addr_q      <= '0;
            count_q     <= 2'd0;
            en_read_q   <= 1'b0;
            signal_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            i_q         <= i_d;
            j_q         <= j_d;
            row_base_q  <= row_base_d;
            prev_base_q <= prev_base_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            en_read_q   <= en_read_d;
            signal_q    <= signal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign addr    = addr_q;
    assign en_read = en_read_q;
    assign count   = count_q;
    assign signal  = signal_q;
    assign i       = i_q;
    assign j       = j_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_read_addr_sequencer.sv
// Self-checking bench for read_addr_sequencer (N=2): cycle-level reference model plus directed literal checks.
module tb_read_addr_sequencer;

    localparam int unsigned TN  = 2;
    localparam int unsigned TAW = 4;
    localparam int unsigned TIW = 2;

`ifdef RD_SEQ_WAIT_ACK_EN
    localparam bit ACK_EN = 1'b1;
    localparam int W_DIR  = 3;
`else
    localparam bit ACK_EN = 1'b0;
    localparam int W_DIR  = 1;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           cell_done = 1'b0;
    logic [TAW-1:0] addr;
    logic           en_read;
    logic [1:0]     count;
    logic           signal;
    logic [TIW-1:0] i, j;
    logic           busy, done;

    read_addr_sequencer #(.N(TN), .ADDR_W(TAW), .IDX_W(TIW)) dut (
        .clk(clk), .rst(rst), .start(start), .cell_done(cell_done),
        .addr(addr), .en_read(en_read), .count(count), .signal(signal),
        .i(i), .j(j), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fill is a list of N*N cells; each cell is a cycle index t
    // (0..5 reads, two cycles per neighbour; 6 publish; 7 waiting for advance).
    typedef enum int {M_IDLE, M_FILL, M_FIN} mmode_t;
    mmode_t m_mode;
    int     m_c, m_t, m_i, m_j, m_addr, m_count;

    function automatic int rd_addr(input int c, input int r);
        int row = c / TN + 1;
        int col = c % TN + 1;
        if (r == 0) return (row - 1) * (TN + 1) + col - 1;
        if (r == 1) return row * (TN + 1) + col - 1;
        return (row - 1) * (TN + 1) + col;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        mmode_t mo;
        int     c, t;
        bit     adv;
        if (!rst) begin
            m_mode  <= M_IDLE;
            m_c     <= 0;
            m_t     <= 0;
            m_i     <= 0;
            m_j     <= 0;
            m_addr  <= 0;
            m_count <= 0;
        end else begin
            mo  = m_mode;
            c   = m_c;
            t   = m_t;
            adv = ACK_EN ? (cell_done === 1'b1) : 1'b1;
            case (m_mode)
                M_IDLE: if (start) begin mo = M_FILL; c = 0; t = 0; end
                M_FILL: begin
                    if (t < 7) t = t + 1;
                    else if (adv) begin
                        if (c == TN * TN - 1) mo = M_FIN;
                        else begin c = c + 1; t = 0; end
                    end
                end
                default: mo = M_IDLE;
            endcase
            m_mode <= mo;
            m_c    <= c;
            m_t    <= t;
            if (mo == M_FILL) begin
                m_i <= c / TN + 1;
                m_j <= c % TN + 1;
            end
            if (mo == M_FILL && t < 6) begin
                m_addr  <= rd_addr(c, t / 2);
                m_count <= t / 2;
            end
        end
    end

    logic e_en, e_sig, e_busy, e_done;
    assign e_en   = (m_mode == M_FILL) && (m_t < 6);
    assign e_sig  = (m_mode == M_FILL) && (m_t == 6);
    assign e_busy = (m_mode != M_IDLE);
    assign e_done = (m_mode == M_FIN);

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy",    32'(busy),    32'(e_busy));
            chk("done",    32'(done),    32'(e_done));
            chk("en_read", 32'(en_read), 32'(e_en));
            chk("signal",  32'(signal),  32'(e_sig));
            chk("i",       32'(i),       32'(m_i));
            chk("j",       32'(j),       32'(m_j));
            chk("addr",    32'(addr),    32'(m_addr));
            if (e_en) chk("count", 32'(count), 32'(m_count));
        end
    end

    // cell_done driver: 0 none, 1 always, 2 ack after 3 WAIT cycles, 3 random, 4 single pulse in RD_LEFT
    int ack_mode = 0;
    int wcnt     = 100;
    bit pulsed   = 1'b0;
    always @(negedge clk) begin
        case (ack_mode)
            1: begin cell_done = 1'b1; pulsed = 1'b0; end
            2: begin
                if (signal) wcnt = 0;
                else wcnt = wcnt + 1;
                cell_done = (wcnt == 3);
                pulsed    = 1'b0;
            end
            3: begin cell_done = ($urandom_range(0, 2) == 0); pulsed = 1'b0; end
            4: begin
                cell_done = !pulsed && en_read && (count == 2'd1);
                if (cell_done) pulsed = 1'b1;
            end
            default: begin cell_done = 1'b0; pulsed = 1'b0; end
        endcase
    end

    int exp_addr[12] = '{0, 3, 1, 1, 4, 2, 3, 6, 4, 4, 7, 5};
    int addrs[$];
    int sig_n, done_n, busy_n;
    bit got;

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr",   32'(addr),    0);
        chk("rst_busy",   32'(busy),    0);
        chk("rst_en",     32'(en_read), 0);
        chk("rst_i",      32'(i),       0);
        chk("rst_j",      32'(j),       0);
        chk("rst_done",   32'(done),    0);
        chk("rst_signal", 32'(signal),  0);
        check_en = 1'b1;
        rst      = 1'b1;

        // Full fill with ack three cycles into each WAIT
        ack_mode = 2;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        sig_n = 0; done_n = 0; busy_n = 0; got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (en_read) addrs.push_back(int'(addr));
            sig_n  += int'(signal);
            done_n += int'(done);
            busy_n += int'(busy);
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        chk("fill_done_seen", 32'(got), 1);
        chk("fill_busy_cycles", 32'(busy_n), 32'(4 * (7 + W_DIR) + 1));
        chk("fill_signal_pulses", 32'(sig_n), 4);
        chk("fill_done_pulses", 32'(done_n), 1);
        chk("fill_read_cycles", 32'(addrs.size()), 24);
        for (int k = 0; k < 24; k++)
            if (k < addrs.size()) chk("fill_addr_seq", 32'(addrs[k]), 32'(exp_addr[k / 2]));
        @(negedge clk);
        chk("fill_back_idle", 32'(busy), 0);
        chk("fill_i_hold", 32'(i), 2);
        chk("fill_j_hold", 32'(j), 2);

`ifdef RD_SEQ_WAIT_ACK_EN
        // cell_done outside WAIT must not be latched
        ack_mode = 4;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (40) @(negedge clk);
        chk("stuck_busy",   32'(busy),    1);
        chk("stuck_en",     32'(en_read), 0);
        chk("stuck_signal", 32'(signal),  0);
        chk("stuck_i",      32'(i),       1);
        chk("stuck_j",      32'(j),       1);
        #2 rst = 1'b0;
        @(negedge clk) rst = 1'b1;
`endif

        // Asynchronous reset during RD_UP of cell (2,1)
        ack_mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (i == 2'd2 && j == 2'd1 && en_read && count == 2'd2) got = 1'b1;
            else @(negedge clk);
        end
        chk("arst_reached_up21", 32'(got), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_addr",   32'(addr),    0);
        chk("arst_en",     32'(en_read), 0);
        chk("arst_count",  32'(count),   0);
        chk("arst_signal", 32'(signal),  0);
        chk("arst_i",      32'(i),       0);
        chk("arst_j",      32'(j),       0);
        chk("arst_busy",   32'(busy),    0);
        chk("arst_done",   32'(done),    0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("restart_addr",  32'(addr),    0);
        chk("restart_i",     32'(i),       1);
        chk("restart_j",     32'(j),       1);
        chk("restart_en",    32'(en_read), 1);
        chk("restart_count", 32'(count),   0);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (!busy) got = 1'b1;
            else @(negedge clk);
        end
        chk("restart_finished", 32'(got), 1);

        // start held high: one idle cycle between fills
        @(negedge clk) start = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("held_done_seen", 32'(got), 1);
        @(negedge clk);
        chk("held_idle_gap", 32'(busy), 0);
        @(negedge clk);
        chk("held_refill_busy", 32'(busy), 1);
        chk("held_refill_addr", 32'(addr), 0);
        chk("held_refill_i",    32'(i),    1);
        chk("held_refill_j",    32'(j),    1);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (!busy) got = 1'b1;
            else @(negedge clk);
        end
        chk("held_finished", 32'(got), 1);

        // Random traffic with occasional asynchronous resets
        ack_mode = 3;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #3 rst = 1'b0;
                @(negedge clk) rst = 1'b1;
            end
        end
        start    = 1'b0;
        ack_mode = 0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/read_addr_sequencer.md
READ_ADDR_SEQUENCER -- requirements
Module: read_addr_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning sequence length; the score matrix is (N+1)x(N+1), row-major.
REQ-002 The block SHALL have parameter ADDR_W, default 7, meaning score-RAM address width; it must satisfy 2^ADDR_W >= (N+1)^2.
REQ-003 The block SHALL have parameter IDX_W, default 4, meaning row/column index width; it must satisfy 2^IDX_W > N.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begin a matrix fill; sampled only in IDLE.
REQ-007 The block SHALL have port cell_done, input, 1 bit: the compute stage has written the current cell.
REQ-008 The block SHALL have port addr, output, ADDR_W bits: score-RAM read address.
REQ-009 The block SHALL have port en_read, output, 1 bit: score-RAM read enable, forwarded to the output manager.
REQ-010 The block SHALL have port count, output, 2 bits: read selector, 0=diag, 1=left, 2=up.
REQ-011 The block SHALL have port signal, output, 1 bit: single-cycle pulse telling the output manager to publish diag/left/up.
REQ-012 The block SHALL have ports i and j, output, IDX_W bits each: current cell row and column.
REQ-013 The block SHALL have ports busy and done, output, 1 bit each: busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, RD_DIAG, RD_LEFT, RD_UP, EMIT, WAIT and FIN.
REQ-015 In IDLE with start=1, the FSM SHALL set i=1 and j=1 and go to RD_DIAG on the next edge.
REQ-016 Each RD_* state SHALL last exactly 2 cycles (address cycle, then data cycle), holding en_read=1 and addr and count stable for both cycles.
REQ-017 The read addresses SHALL be: RD_DIAG addr=(i-1)(N+1)+(j-1), count=0; RD_LEFT addr=i(N+1)+(j-1), count=1; RD_UP addr=(i-1)(N+1)+j, count=2.
REQ-018 Addresses SHALL be formed from a registered row base i(N+1) and the previous row base, updated by adding N+1 per row; no multiplier.
REQ-019 EMIT SHALL last 1 cycle with signal=1 and en_read=0, then go to WAIT.
REQ-020 WAIT SHALL hold en_read=0 and signal=0 until cell_done=1.
REQ-021 On cell_done with j<N, the block SHALL set j=j+1 and go to RD_DIAG.
REQ-022 On cell_done with j=N and i<N, the block SHALL set j=1 and i=i+1, advance the row bases, and go to RD_DIAG.
REQ-023 On cell_done with i=N and j=N, the block SHALL go to FIN.
REQ-024 FIN SHALL last 1 cycle with done=1, then go to IDLE; i and j hold their last values.
REQ-025 cell_done outside WAIT SHALL be ignored and not latched.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 Latency SHALL be: first RD_DIAG address appears 1 cycle after start; each cell takes 7 cycles plus the WAIT time.
REQ-028 In IDLE, WAIT and FIN, addr SHALL hold its last value.

Reset
REQ-029 When rst=0, the block SHALL immediately enter IDLE and drive addr=0, en_read=0, count=0, signal=0, i=0, j=0, busy=0 and done=0.
REQ-030 Reset asserted mid-fill SHALL abandon the fill, with no done pulse and no resume.

Configuration
REQ-031 With macro RD_SEQ_WAIT_ACK_EN defined, WAIT SHALL behave as specified above.
REQ-032 Without RD_SEQ_WAIT_ACK_EN, WAIT SHALL last exactly 1 cycle, cell advance SHALL proceed as if cell_done=1, and the cell_done port SHALL remain present but unused.

Verification
REQ-033 Scenario (N=2, macro defined): pulse start, ack each WAIT after 3 cycles -> cell (1,1) addr 0,3,1; (1,2) 1,4,2; (2,1) 3,6,4; (2,2) 4,7,5; four signal pulses, then one done pulse.
REQ-034 Scenario: check count and addr over each RD_* phase -> both stable for exactly 2 cycles with en_read=1; signal high exactly 1 cycle after the RD_UP data cycle.
REQ-035 Scenario: pulse cell_done during RD_LEFT, then never in WAIT -> the block stays in WAIT with i=1, j=1 and no further reads.
REQ-036 Scenario: assert rst=0 asynchronously during RD_UP of cell (2,1) -> outputs zero without waiting for a clock edge; a new start restarts at cell (1,1), addr 0.
REQ-037 Scenario (macro undefined, N=2, cell_done tied 0) -> full fill completes in 4x8+2 cycles from start, ending in a done pulse.
REQ-038 Scenario: hold start=1 continuously -> exactly one fill per pass through IDLE; a new fill begins the cycle after FIN returns to IDLE.
